// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared integer ALU.
// One operation in flight; each requester owns a one-deep response slot.
module alu_arbiter #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2*DW-1:0] req_a,
   input  logic [2*DW-1:0] req_b,
   input  logic [5:0]      req_op,
   output logic [1:0]      rsp_valid,
   input  logic [1:0]      rsp_ready,
   output logic [2*DW-1:0] rsp_y,
   output logic [1:0]      rsp_overflow,
   output logic [1:0]      rsp_zero,
   output logic            busy
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // req_ready is the combinational grant, rsp_valid is registered and held until consumed.

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                gsel_q, gsel_d;
   logic [DW-1:0]       a_q, a_d;
   logic [DW-1:0]       b_q, b_d;
   logic [2:0]          op_q, op_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [1:0][DW-1:0]  rsp_y_q;
   logic [1:0]          rsp_ovf_q;
   logic [1:0]          rsp_zero_q;

   logic [1:0]          elig;
   logic [1:0]          grant;
   logic                accept;

   logic [DW-1:0]       b_eff;
   logic [DW-1:0]       sum;
   logic [DW-1:0]       alu_y;
   logic                alu_ovf;

   // A full response slot blocks its owner until the slot is drained.
   assign elig = req_valid & ~rsp_valid_q;

   always_comb begin
      grant = 2'b00;
      if (resetn && (state_q == S_IDLE)) begin
         case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign accept = |grant;
   assign gsel_d = grant[1];

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d      = S_EXEC;
               last_grant_d = gsel_d;
               a_d          = gsel_d ? req_a[2*DW-1:DW] : req_a[DW-1:0];
               b_d          = gsel_d ? req_b[2*DW-1:DW] : req_b[DW-1:0];
               op_d         = gsel_d ? req_op[5:3]      : req_op[2:0];
            end
         end
         S_EXEC: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // op[2] selects ~b with carry-in 1, giving subtraction and the SLT compare.
   always_comb begin
      b_eff   = op_q[2] ? ~b_q : b_q;
      sum     = a_q + b_eff + {{(DW-1){1'b0}}, op_q[2]};
      alu_ovf = 1'b0;
      case (op_q[1:0])
         2'b00:   alu_y = a_q & b_eff;
         2'b01:   alu_y = a_q | b_eff;
         2'b10: begin
            alu_y   = sum;
            alu_ovf = (a_q[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_q[DW-1]);
         end
         default: alu_y = {{(DW-1){1'b0}}, sum[DW-1]};
      endcase
   end

   // Drain and writeback never target the same slot: the written slot was empty at grant.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      if (state_q == S_EXEC) begin
         rsp_valid_d[gsel_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         gsel_q       <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         if (accept) begin
            gsel_q <= gsel_d;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid_q <= '0;
         rsp_y_q     <= '0;
         rsp_ovf_q   <= '0;
         rsp_zero_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (state_q == S_EXEC) begin
            rsp_y_q[gsel_q]    <= alu_y;
            rsp_ovf_q[gsel_q]  <= alu_ovf;
            rsp_zero_q[gsel_q] <= (alu_y == '0);
         end
      end
   end

   assign req_ready    = grant;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_y        = rsp_y_q;
   assign rsp_overflow = rsp_ovf_q;
   assign rsp_zero     = rsp_zero_q;
   assign busy         = (state_q == S_EXEC);

   a_grant_onehot: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(req_ready));

   a_no_grant_exec: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == S_EXEC) |-> (req_ready == 2'b00));

endmodule
